// File: rtl/udp_rx_parser.sv
// udp_rx_parser: parses the UDP header from the IP decoder payload stream,
// forwards payload words with byte-keep, and issues a one-cycle verdict
// (done/pkt_ok/err_code) after checking length and pseudo-header checksum.
module udp_rx_parser #(
  parameter logic [15:0] LOCAL_PORT = 16'd0,
  parameter logic        FILTER_EN  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        wr_en_in,
  input  logic        fin_in,
  input  logic        ok_in,
  input  logic [15:0] len_in,
  input  logic [31:0] src_ip,
  input  logic [31:0] dest_ip,
  input  logic [7:0]  protocol,
  output logic [15:0] src_port,
  output logic [15:0] dst_port,
  output logic [15:0] udp_length,
  output logic [31:0] data_out,
  output logic [3:0]  keep,
  output logic        valid_out,
  output logic        last_out,
  output logic        done,
  output logic        pkt_ok,
  output logic [2:0]  err_code
);

  typedef enum logic [1:0] {IDLE, HDR1, PAYLOAD, DROP} state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_PROTO = 3'd1;
  localparam logic [2:0] ERR_PORT  = 3'd2;
  localparam logic [2:0] ERR_LEN   = 3'd3;
  localparam logic [2:0] ERR_SHORT = 3'd4;
  localparam logic [2:0] ERR_CSUM  = 3'd5;
  localparam logic [2:0] ERR_TRUNC = 3'd6;

  state_t      state;
  logic [31:0] acc;
  logic [15:0] remaining;
  logic [15:0] csum_field;
  logic [2:0]  drop_err;

  logic [31:0] word_sum;
  logic [31:0] pseudo_sum;
  logic [15:0] hdr_len;
  logic [31:0] acc_hdr;
  logic [31:0] acc_pay;
  logic [15:0] rem_after;
  logic [3:0]  keep_next;
  logic [2:0]  idle_err;
  logic [2:0]  hdr_err;
  logic [2:0]  hdr_verdict;
  logic [2:0]  pay_verdict;

  // Ones-complement fold: the carry is added back twice so the result fits in 16 bits.
  function automatic logic [15:0] fold(input logic [31:0] s);
    logic [16:0] t1;
    logic [16:0] t2;
    t1 = {1'b0, s[15:0]} + {1'b0, s[31:16]};
    t2 = {1'b0, t1[15:0]} + {16'd0, t1[16]};
    return t2[15:0];
  endfunction

  // Next-state arithmetic for the accumulator, byte counter and verdicts of each state.
  always_comb begin
    word_sum    = {16'd0, data_in[31:16]} + {16'd0, data_in[15:0]};
    pseudo_sum  = {16'd0, src_ip[31:16]} + {16'd0, src_ip[15:0]}
                + {16'd0, dest_ip[31:16]} + {16'd0, dest_ip[15:0]} + 32'h0000_0011;
    hdr_len     = data_in[31:16];
    acc_hdr     = acc + {16'd0, hdr_len} + {16'd0, hdr_len} + {16'd0, data_in[15:0]};
    acc_pay     = (remaining != 16'd0) ? acc + word_sum : acc;
    rem_after   = (remaining >= 16'd4) ? remaining - 16'd4 : 16'd0;
    keep_next   = 4'b0000;
    if (remaining >= 16'd4) begin
      keep_next = 4'b1111;
    end else begin
      case (remaining[1:0])
        2'd3:    keep_next = 4'b1110;
        2'd2:    keep_next = 4'b1100;
        2'd1:    keep_next = 4'b1000;
        default: keep_next = 4'b0000;
      endcase
    end

    idle_err = ERR_NONE;
    if (protocol != 8'd17 || !ok_in) begin
      idle_err = ERR_PROTO;
    end else if (FILTER_EN && data_in[15:0] != LOCAL_PORT) begin
      idle_err = ERR_PORT;
    end

    hdr_err = ERR_NONE;
    if (hdr_len < 16'd8) begin
      hdr_err = ERR_SHORT;
    end else if (hdr_len != len_in) begin
      hdr_err = ERR_LEN;
    end

    hdr_verdict = ERR_NONE;
    if (hdr_len != 16'd8) begin
      hdr_verdict = ERR_TRUNC;
    end else if (data_in[15:0] != 16'd0 && fold(acc_hdr) != 16'hFFFF) begin
      hdr_verdict = ERR_CSUM;
    end

    pay_verdict = ERR_NONE;
    if (rem_after != 16'd0) begin
      pay_verdict = ERR_TRUNC;
    end else if (csum_field != 16'd0 && fold(acc_pay) != 16'hFFFF) begin
      pay_verdict = ERR_CSUM;
    end
  end

  // Parser state machine: header capture, payload forwarding and registered verdict.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= 32'd0;
      remaining  <= 16'd0;
      csum_field <= 16'd0;
      drop_err   <= ERR_NONE;
      src_port   <= 16'd0;
      dst_port   <= 16'd0;
      udp_length <= 16'd0;
      data_out   <= 32'd0;
      keep       <= 4'd0;
      valid_out  <= 1'b0;
      last_out   <= 1'b0;
      done       <= 1'b0;
      pkt_ok     <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      data_out  <= 32'd0;
      keep      <= 4'd0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      done      <= 1'b0;
      pkt_ok    <= 1'b0;
      err_code  <= ERR_NONE;
      if (wr_en_in) begin
        case (state)
          IDLE: begin
            src_port <= data_in[31:16];
            dst_port <= data_in[15:0];
            acc      <= pseudo_sum + word_sum;
            if (fin_in) begin
              done     <= 1'b1;
              err_code <= (idle_err != ERR_NONE) ? idle_err : ERR_TRUNC;
              state    <= IDLE;
            end else if (idle_err != ERR_NONE) begin
              drop_err <= idle_err;
              state    <= DROP;
            end else begin
              state <= HDR1;
            end
          end
          HDR1: begin
            udp_length <= hdr_len;
            csum_field <= data_in[15:0];
            acc        <= acc_hdr;
            remaining  <= hdr_len - 16'd8;
            if (hdr_err != ERR_NONE) begin
              if (fin_in) begin
                done     <= 1'b1;
                err_code <= hdr_err;
                state    <= IDLE;
              end else begin
                drop_err <= hdr_err;
                state    <= DROP;
              end
            end else if (fin_in) begin
              done     <= 1'b1;
              err_code <= hdr_verdict;
              pkt_ok   <= (hdr_verdict == ERR_NONE);
              state    <= IDLE;
            end else begin
              state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            if (remaining != 16'd0) begin
              acc       <= acc_pay;
              data_out  <= data_in;
              keep      <= keep_next;
              valid_out <= 1'b1;
              last_out  <= (rem_after == 16'd0);
              remaining <= rem_after;
            end
            if (fin_in) begin
              done     <= 1'b1;
              err_code <= pay_verdict;
              pkt_ok   <= (pay_verdict == ERR_NONE);
              state    <= IDLE;
            end
          end
          DROP: begin
            if (fin_in) begin
              done     <= 1'b1;
              err_code <= drop_err;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udp_rx_parser.sv
// tb_udp_rx_parser: directed and randomized packets driven into an unfiltered
// and a port-filtered parser, checked against a byte-level reference model.
module tb_udp_rx_parser;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in = 32'd0;
  logic        wr_en_in = 1'b0;
  logic        fin_in = 1'b0;
  logic        ok_in = 1'b1;
  logic [15:0] len_in = 16'd0;
  logic [31:0] src_ip = 32'd0;
  logic [31:0] dest_ip = 32'd0;
  logic [7:0]  protocol = 8'd17;

  logic [15:0] a_src_port, a_dst_port, a_udp_length;
  logic [31:0] a_data_out;
  logic [3:0]  a_keep;
  logic        a_valid_out, a_last_out, a_done, a_pkt_ok;
  logic [2:0]  a_err_code;
  logic [15:0] f_src_port, f_dst_port, f_udp_length;
  logic [31:0] f_data_out;
  logic [3:0]  f_keep;
  logic        f_valid_out, f_last_out, f_done, f_pkt_ok;
  logic [2:0]  f_err_code;

  udp_rx_parser dut_a (
    .clk(clk), .reset(reset), .data_in(data_in), .wr_en_in(wr_en_in), .fin_in(fin_in),
    .ok_in(ok_in), .len_in(len_in), .src_ip(src_ip), .dest_ip(dest_ip), .protocol(protocol),
    .src_port(a_src_port), .dst_port(a_dst_port), .udp_length(a_udp_length),
    .data_out(a_data_out), .keep(a_keep), .valid_out(a_valid_out), .last_out(a_last_out),
    .done(a_done), .pkt_ok(a_pkt_ok), .err_code(a_err_code)
  );

  udp_rx_parser #(.LOCAL_PORT(16'h0050), .FILTER_EN(1'b1)) dut_f (
    .clk(clk), .reset(reset), .data_in(data_in), .wr_en_in(wr_en_in), .fin_in(fin_in),
    .ok_in(ok_in), .len_in(len_in), .src_ip(src_ip), .dest_ip(dest_ip), .protocol(protocol),
    .src_port(f_src_port), .dst_port(f_dst_port), .udp_length(f_udp_length),
    .data_out(f_data_out), .keep(f_keep), .valid_out(f_valid_out), .last_out(f_last_out),
    .done(f_done), .pkt_ok(f_pkt_ok), .err_code(f_err_code)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic [31:0] c;
  } word_t;

  typedef struct packed {
    logic        ok;
    logic [2:0]  e;
    logic [31:0] c;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [15:0] ul;
  } done_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int f_words = 0;
  int exp_f_words = 0;
  logic [15:0] hold_len = 16'd0;

  word_t obs_w[$];
  word_t exp_w[$];
  done_t obs_d[$];
  done_t exp_d[$];
  done_t obs_fd[$];
  done_t exp_fd[$];

  logic [31:0] pw[$];
  logic [3:0]  m_keep[64];
  logic        m_last[64];

  // Free-running clock and cycle stamp used to time every observed output.
  always #5 clk = ~clk;

  // Cycle counter advanced on each active edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor sampling on the inactive edge.
  always @(negedge clk) begin
    if (a_valid_out) obs_w.push_back(word_t'{a_data_out, a_keep, a_last_out, cyc});
    if (a_done) obs_d.push_back(done_t'{a_pkt_ok, a_err_code, cyc, a_src_port, a_dst_port, a_udp_length});
    if (f_valid_out) f_words++;
    if (f_done) obs_fd.push_back(done_t'{f_pkt_ok, f_err_code, cyc, 16'h0, 16'h0, 16'h0});
  end

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] byte_at(input int k);
    logic [31:0] w;
    if (k / 4 >= pw.size()) return 8'h00;
    w = pw[k / 4];
    return w[31 - 8 * (k % 4) -: 8];
  endfunction

  // RFC 768 style ones-complement sum over pseudo-header and ulen UDP bytes.
  function automatic logic [15:0] ones_sum(input int ulen);
    logic [31:0] s;
    s = src_ip[31:16] + src_ip[15:0] + dest_ip[31:16] + dest_ip[15:0] + 32'd17 + ulen;
    for (int k = 0; k < ulen; k += 2)
      s += {16'h0, byte_at(k), ((k + 1 < ulen) ? byte_at(k + 1) : 8'h00)};
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  // Reference model: verdict and per-beat forwarding for a packet of nb beats.
  task automatic run_model(input bit filt, input logic [15:0] lport, input int nb,
                           output logic [2:0] err, output int nwords);
    int ulen;
    int off;
    int n;
    logic [15:0] csf;
    ulen = int'({byte_at(4), byte_at(5)});
    csf = {byte_at(6), byte_at(7)};
    for (int i = 0; i < 64; i++) begin
      m_keep[i] = 4'h0;
      m_last[i] = 1'b0;
    end
    nwords = 0;
    err = 3'd0;
    if (protocol != 8'd17 || !ok_in) err = 3'd1;
    else if (filt && {byte_at(2), byte_at(3)} != lport) err = 3'd2;
    else if (nb < 2) err = 3'd6;
    else if (ulen < 8) err = 3'd4;
    else if (ulen != int'(len_in)) err = 3'd3;
    else begin
      for (int b = 2; b < nb; b++) begin
        off = 4 * b;
        if (off < ulen) begin
          n = (ulen - off >= 4) ? 4 : ulen - off;
          m_keep[b] = 4'hF << (4 - n);
          m_last[b] = (off + 4 >= ulen);
          nwords++;
        end
      end
      if (4 * nb < ulen) err = 3'd6;
      else if (csf != 16'h0 && ones_sum(ulen) != 16'hFFFF) err = 3'd5;
    end
  endtask

  task automatic idle(input int n);
    wr_en_in = 1'b0;
    fin_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Drives nb beats of pw with random gaps; reset_at >= 0 aborts with reset on that beat.
  task automatic apply_stimulus(input int nb, input int gap_max, input int reset_at);
    logic [2:0] ea;
    logic [2:0] ef;
    int nwa;
    int nwf;
    int fin_cyc;
    logic [15:0] ulen;
    fin_cyc = 0;
    ulen = {byte_at(4), byte_at(5)};
    run_model(1'b1, 16'h0050, nb, ef, nwf);
    run_model(1'b0, 16'h0000, nb, ea, nwa);
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, gap_max)) begin
        wr_en_in = 1'b0;
        data_in = $urandom;
        fin_in = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      wr_en_in = 1'b1;
      data_in = (b < pw.size()) ? pw[b] : $urandom;
      fin_in = (b == nb - 1);
      if (b == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        check_output("reset_outputs_a", {a_valid_out, a_done, a_data_out, a_keep, a_last_out, a_pkt_ok,
                     a_err_code, a_src_port, a_dst_port, a_udp_length}, 128'd0);
        check_output("reset_outputs_f", {f_valid_out, f_done, f_pkt_ok, f_err_code}, 128'd0);
        reset = 1'b0;
        wr_en_in = 1'b0;
        fin_in = 1'b0;
        hold_len = 16'd0;
        return;
      end
      if (m_keep[b] != 4'h0) exp_w.push_back(word_t'{data_in, m_keep[b], m_last[b], cyc + 1});
      fin_cyc = cyc;
      @(negedge clk);
    end
    wr_en_in = 1'b0;
    fin_in = 1'b0;
    if (nb >= 2 && ea != 3'd1) hold_len = ulen;
    exp_d.push_back(done_t'{(ea == 3'd0), ea, fin_cyc + 1, {byte_at(0), byte_at(1)},
                            {byte_at(2), byte_at(3)}, hold_len});
    exp_fd.push_back(done_t'{(ef == 3'd0), ef, fin_cyc + 1, 16'h0, 16'h0, 16'h0});
    exp_f_words += nwf;
  endtask

  // Compares everything the monitor collected against the model, then clears it.
  task automatic check_scoreboard(input string tag);
    check_output({tag, "_word_count"}, obs_w.size(), exp_w.size());
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++)
      check_output($sformatf("%s_word%0d", tag, i), obs_w[i], exp_w[i]);
    check_output({tag, "_done_count"}, obs_d.size(), exp_d.size());
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++)
      check_output($sformatf("%s_done%0d", tag, i), obs_d[i], exp_d[i]);
    check_output({tag, "_fdone_count"}, obs_fd.size(), exp_fd.size());
    for (int i = 0; i < obs_fd.size() && i < exp_fd.size(); i++)
      check_output($sformatf("%s_fdone%0d", tag, i), obs_fd[i], exp_fd[i]);
    check_output({tag, "_f_words"}, f_words, exp_f_words);
    obs_w.delete();
    exp_w.delete();
    obs_d.delete();
    exp_d.delete();
    obs_fd.delete();
    exp_fd.delete();
  endtask

  task automatic load_vector();
    src_ip = 32'h9801_331b;
    dest_ip = 32'h980e_5e4b;
    protocol = 8'd17;
    ok_in = 1'b1;
    len_in = 16'd19;
    pw = {32'h1234_0035, 32'h0013_da1a, 32'h4865_6c6c, 32'h6f20_576f, 32'h726c_6400};
  endtask

  // Random packet with a correct checksum, then one of several faults injected.
  task automatic make_random(output int nb);
    int plen;
    int ulen;
    int mode;
    int r;
    logic [31:0] w;
    logic [15:0] cs;
    plen = $urandom_range(1, 32);
    ulen = plen + 8;
    mode = $urandom_range(0, 11);
    src_ip = $urandom;
    dest_ip = $urandom;
    protocol = 8'd17;
    ok_in = 1'b1;
    len_in = 16'(ulen);
    pw.delete();
    pw.push_back({16'($urandom), ($urandom_range(0, 1) != 0) ? 16'h0050 : 16'($urandom)});
    pw.push_back({16'(ulen), 16'h0000});
    for (int k = 0; k < plen; k += 4) begin
      w = $urandom;
      r = plen - k;
      if (r < 4) w = w & (32'hFFFF_FFFF << (8 * (4 - r)));
      pw.push_back(w);
    end
    cs = ~ones_sum(ulen);
    if (cs == 16'h0) cs = 16'hFFFF;
    pw[1] = {16'(ulen), cs};
    nb = pw.size();
    case (mode)
      0: protocol = 8'd6;
      1: ok_in = 1'b0;
      2: len_in = 16'(ulen + 4);
      3: nb = $urandom_range(1, pw.size() - 1);
      4: pw[1] = {16'(ulen), cs ^ 16'h0100};
      5: pw[1] = {16'(ulen), 16'h0000};
      6: nb = nb + $urandom_range(1, 3);
      7: pw[1] = {16'($urandom_range(0, 7)), cs};
      default: ;
    endcase
  endtask

  initial begin
    int nb;
    repeat (3) @(negedge clk);
    check_output("reset_state", {a_valid_out, a_done, a_data_out, a_keep, a_last_out, a_pkt_ok,
                 a_err_code, a_src_port, a_dst_port, a_udp_length}, 128'd0);
    reset = 1'b0;
    idle(2);

    load_vector();
    apply_stimulus(5, 0, -1);
    apply_stimulus(5, 0, -1);
    idle(3);
    check_scoreboard("good_b2b");

    pw[1] = 32'h0013_0000;
    apply_stimulus(5, 0, -1);
    pw[1] = 32'h0013_da1b;
    apply_stimulus(5, 0, -1);
    idle(3);
    check_scoreboard("csum");

    load_vector();
    protocol = 8'd6;
    apply_stimulus(5, 0, -1);
    protocol = 8'd17;
    len_in = 16'd20;
    apply_stimulus(5, 0, -1);
    len_in = 16'd19;
    pw[1] = 32'h0004_da1a;
    apply_stimulus(5, 0, -1);
    idle(3);
    check_scoreboard("hdr_errs");

    load_vector();
    apply_stimulus(3, 0, -1);
    idle(3);
    check_scoreboard("trunc");

    apply_stimulus(5, 0, 3);
    idle(2);
    apply_stimulus(5, 0, -1);
    idle(3);
    check_scoreboard("reset_mid");

    for (int i = 0; i < 3; i++) apply_stimulus(5, 3, -1);
    idle(3);
    check_scoreboard("gaps");

    for (int p = 0; p < 48; p++) begin
      make_random(nb);
      apply_stimulus(nb, $urandom_range(0, 2), -1);
      if (p % 4 == 3) begin
        idle(3);
        check_scoreboard($sformatf("rand%0d", p));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
